// File: rtl/enc_req_arbiter.sv
// enc_req_arbiter
// Shares a single block-encryptor core between NUM_REQ requesters using a
// round-robin grant. One 128-bit block is processed per grant; the core inputs
// are held for the whole operation and a watchdog ends a hung operation with an
// error response and a sticky fault flag.
module enc_req_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   mclk,
  input  logic                   srst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plaintext,
  input  logic [NUM_REQ*2-1:0]   req_keylen,
  output logic                   start_enc,
  output logic [127:0]           plaintext,
  output logic                   keylength128,
  output logic                   keylength192,
  output logic                   keylength256,
  input  logic                   ciphertext_dv,
  input  logic [127:0]           ciphertext,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [127:0]           rsp_ciphertext,
  output logic                   rsp_err,
  output logic                   enc_fault,
  output logic                   busy
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      rr_ptr_r;
  logic [1:0]      rr_next_s;
  logic [1:0]      grant_idx_s;
  logic            grant_found_s;
  logic            grant_ok_s;
  logic            timeout_s;
  logic [3:0]      valid_pad_s;
  logic [2:0]      sum_s;
  logic [127:0]    sel_pt_s;
  logic [1:0]      sel_kl_s;
  logic [WD_W-1:0] wd_cnt_r;

  // Key-length code to one-hot {256,192,128}; the spare code 11 means 128.
  function automatic logic [2:0] decode_keylen(input logic [1:0] kl);
    case (kl)
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // Round-robin search from rr_ptr, requester data mux and the grant pulse.
  always_comb begin
    valid_pad_s   = 4'(req_valid);
    grant_found_s = 1'b0;
    grant_idx_s   = 2'd0;
    sum_s         = 3'd0;
    sel_pt_s      = 128'd0;
    sel_kl_s      = 2'd0;
    req_ready     = {NUM_REQ{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + 3'(k);
      if (sum_s >= 3'(NUM_REQ)) begin
        sum_s = sum_s - 3'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!grant_found_s && valid_pad_s[sum_s[1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = sum_s[1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx_s == 2'(k)) begin
        sel_pt_s = req_plaintext[k*128 +: 128];
        sel_kl_s = req_keylen[k*2 +: 2];
      end else begin
        sel_pt_s = sel_pt_s;
      end
    end
    grant_ok_s = (state_r == ST_IDLE) && !enc_fault && grant_found_s;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = grant_ok_s && (grant_idx_s == 2'(k));
    end
    if (grant_idx_s == 2'(NUM_REQ - 1)) begin
      rr_next_s = 2'd0;
    end else begin
      rr_next_s = grant_idx_s + 2'd1;
    end
    timeout_s = (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
  end

  // Next-state decode of the grant / launch / wait / respond sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_ok_s) state_s = ST_LAUNCH;
        else            state_s = ST_IDLE;
      end
      ST_LAUNCH: state_s = ST_WAIT;
      ST_WAIT: begin
        if (ciphertext_dv)  state_s = ST_RESP;
        else if (timeout_s) state_s = ST_RESP;
        else                state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_ready) state_s = ST_IDLE;
        else           state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, registered status outputs, core drive and response capture.
  always_ff @(posedge mclk) begin
    if (srst) begin
      state_r        <= ST_IDLE;
      rr_ptr_r       <= 2'd0;
      wd_cnt_r       <= {WD_W{1'b0}};
      start_enc      <= 1'b0;
      rsp_valid      <= 1'b0;
      busy           <= 1'b0;
      plaintext      <= 128'd0;
      keylength128   <= 1'b0;
      keylength192   <= 1'b0;
      keylength256   <= 1'b0;
      rsp_id         <= 2'd0;
      rsp_ciphertext <= 128'd0;
      rsp_err        <= 1'b0;
      enc_fault      <= 1'b0;
    end else begin
      state_r   <= state_s;
      start_enc <= (state_s == ST_LAUNCH);
      rsp_valid <= (state_s == ST_RESP);
      busy      <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (grant_ok_s) begin
            plaintext <= sel_pt_s;
            {keylength256, keylength192, keylength128} <= decode_keylen(sel_kl_s);
            rsp_id    <= grant_idx_s;
            rr_ptr_r  <= rr_next_s;
          end
        end
        ST_LAUNCH: wd_cnt_r <= {WD_W{1'b0}};
        ST_WAIT: begin
          wd_cnt_r <= wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
          if (ciphertext_dv) begin
            rsp_ciphertext <= ciphertext;
            rsp_err        <= 1'b0;
          end else if (timeout_s) begin
            rsp_ciphertext <= 128'd0;
            rsp_err        <= 1'b1;
            enc_fault      <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            plaintext    <= 128'd0;
            keylength128 <= 1'b0;
            keylength192 <= 1'b0;
            keylength256 <= 1'b0;
          end
        end
        default: wd_cnt_r <= {WD_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_enc_req_arbiter.sv
// tb_enc_req_arbiter
// Directed bench for enc_req_arbiter with a behavioural stand-in for the core:
// it answers after 10/12/14 rounds depending on key length and can be muted.
module tb_enc_req_arbiter;

  localparam int          TIMEOUT = 64;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb70a70b4c55a;
  localparam logic [127:0] PT1     = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  logic         mclk = 1'b0;
  logic         srst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [255:0] req_plaintext = 256'd0;
  logic [3:0]   req_keylen = 4'b0000;
  logic         start_enc;
  logic [127:0] plaintext;
  logic         keylength128, keylength192, keylength256;
  logic         ciphertext_dv = 1'b0;
  logic [127:0] ciphertext = 128'd0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_ciphertext;
  logic         rsp_err;
  logic         enc_fault;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 mclk = ~mclk;

  enc_req_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(TIMEOUT)) dut (
    .mclk(mclk), .srst(srst), .req_valid(req_valid), .req_ready(req_ready),
    .req_plaintext(req_plaintext), .req_keylen(req_keylen), .start_enc(start_enc),
    .plaintext(plaintext), .keylength128(keylength128), .keylength192(keylength192),
    .keylength256(keylength256), .ciphertext_dv(ciphertext_dv), .ciphertext(ciphertext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_ciphertext(rsp_ciphertext), .rsp_err(rsp_err), .enc_fault(enc_fault), .busy(busy)
  );

  // Stand-in core result: the FIPS-197 vector, otherwise a fixed scramble.
  function automatic logic [127:0] core_model(input logic [127:0] pt);
    if (pt == FIPS_PT) return FIPS_CT;
    return {pt[63:0], pt[127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction

  logic         core_mute = 1'b0;
  logic         core_busy = 1'b0;
  int           core_cnt  = 0;
  logic [127:0] core_pt   = 128'd0;
  int           start_cnt = 0;

  // Core model: latch block on start_enc, pulse dv after the round count.
  always @(posedge mclk) begin
    ciphertext_dv <= 1'b0;
    if (start_enc === 1'b1) begin
      start_cnt <= start_cnt + 1;
      core_busy <= 1'b1;
      core_pt   <= plaintext;
      core_cnt  <= keylength256 ? 14 : (keylength192 ? 12 : 10);
    end else if (core_busy) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_busy <= 1'b0;
        if (!core_mute) begin
          ciphertext_dv <= 1'b1;
          ciphertext    <= core_model(core_pt);
        end
      end
    end
  end

  // Wait (bounded) for a nonzero req_ready; called at a falling edge.
  task automatic wait_grant(input int max_cyc, output logic [1:0] g, output bit ok);
    ok = 1'b0;
    g  = 2'b00;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (req_ready !== 2'b00) begin
        g  = req_ready;
        ok = 1'b1;
        break;
      end
      @(negedge mclk);
    end
  endtask

  // Count falling edges (bounded) until rsp_valid is seen.
  task automatic wait_rsp(input int max_cyc, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < max_cyc) begin
      @(negedge mclk);
      cyc++;
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(negedge mclk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got %b want 00", req_ready); else n_pass++;
    n_total++; if (start_enc !== 1'b0) $display("FAIL reset_start got %0b want 0", start_enc); else n_pass++;
    n_total++; if (plaintext !== 128'd0) $display("FAIL reset_plaintext got %h want 0", plaintext); else n_pass++;
    n_total++; if ({keylength256, keylength192, keylength128} !== 3'b000)
      $display("FAIL reset_keylen got %b want 000", {keylength256, keylength192, keylength128}); else n_pass++;
    n_total++; if ({rsp_valid, rsp_err, enc_fault, rsp_id} !== 5'b00000)
      $display("FAIL reset_rsp got %b want 00000", {rsp_valid, rsp_err, enc_fault, rsp_id}); else n_pass++;
    n_total++; if (rsp_ciphertext !== 128'd0) $display("FAIL reset_rsp_ct got %h want 0", rsp_ciphertext); else n_pass++;
    srst = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] g; bit ok; int cyc;
    @(negedge mclk);
    req_plaintext[127:0] = FIPS_PT;
    req_keylen = 4'b0000;
    req_valid = 2'b01;
    wait_grant(4, g, ok);
    n_total++; if (!ok || g !== 2'b01) $display("FAIL single_grant got %b want 01", g); else n_pass++;
    @(negedge mclk);
    req_valid = 2'b00;
    n_total++; if ({start_enc, busy, keylength128, keylength192, keylength256} !== 5'b11100)
      $display("FAIL single_launch got %b want 11100", {start_enc, busy, keylength128, keylength192, keylength256}); else n_pass++;
    n_total++; if (plaintext !== FIPS_PT) $display("FAIL single_plaintext got %h want %h", plaintext, FIPS_PT); else n_pass++;
    wait_rsp(40, cyc, ok);
    n_total++; if (!ok || cyc != 12) $display("FAIL single_latency got %0d want 12", cyc); else n_pass++;
    n_total++; if (rsp_ciphertext !== FIPS_CT) $display("FAIL single_ct got %h want %h", rsp_ciphertext, FIPS_CT); else n_pass++;
    n_total++; if ({rsp_id, rsp_err} !== 3'b000) $display("FAIL single_id_err got %b want 000", {rsp_id, rsp_err}); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge mclk);
    rsp_ready = 1'b0;
    n_total++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL single_done got %b want 00", {busy, rsp_valid}); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]   exp_g [3] = '{2'b01, 2'b10, 2'b01};
    logic [1:0]   exp_id[3] = '{2'd0, 2'd1, 2'd0};
    logic [127:0] exp_ct[3];
    logic [1:0] g; bit ok; int cyc; int s0;
    exp_ct[0] = FIPS_CT; exp_ct[1] = core_model(PT1); exp_ct[2] = FIPS_CT;
    @(negedge mclk);
    srst = 1'b1;
    @(negedge mclk);
    srst = 1'b0;
    req_plaintext = {PT1, FIPS_PT};
    req_keylen = 4'b0000;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int t = 0; t < 3; t++) begin
      s0 = start_cnt;
      wait_grant(6, g, ok);
      n_total++; if (!ok || g !== exp_g[t]) $display("FAIL rr_grant%0d got %b want %b", t, g, exp_g[t]); else n_pass++;
      @(negedge mclk);
      wait_rsp(40, cyc, ok);
      n_total++; if (!ok || rsp_id !== exp_id[t] || rsp_ciphertext !== exp_ct[t])
        $display("FAIL rr_rsp%0d got id %0d ct %h want id %0d ct %h", t, rsp_id, rsp_ciphertext, exp_id[t], exp_ct[t]); else n_pass++;
      @(negedge mclk);
      n_total++; if (start_cnt - s0 != 1) $display("FAIL rr_starts%0d got %0d want 1", t, start_cnt - s0); else n_pass++;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    @(negedge mclk);
  endtask

  task automatic test_backpressure();
    logic [1:0] g; bit ok; int cyc; bit stable;
    req_plaintext = {PT1, FIPS_PT};
    req_valid = 2'b01;
    wait_grant(6, g, ok);
    n_total++; if (!ok || g !== 2'b01) $display("FAIL bp_grant got %b want 01", g); else n_pass++;
    @(negedge mclk);
    req_valid = 2'b11;
    wait_rsp(40, cyc, ok);
    stable = ok;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_ciphertext !== FIPS_CT || rsp_err !== 1'b0 || req_ready !== 2'b00)
        stable = 1'b0;
      @(negedge mclk);
    end
    n_total++; if (!stable) $display("FAIL bp_stable got valid %0b id %0d ct %h ready %b want 1 0 %h 00",
      rsp_valid, rsp_id, rsp_ciphertext, req_ready, FIPS_CT); else n_pass++;
    rsp_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 2'b00) $display("FAIL bp_no_grant_in_resp got %b want 00", req_ready); else n_pass++;
    @(negedge mclk);
    rsp_ready = 1'b0;
    #1;
    n_total++; if (req_ready !== 2'b10) $display("FAIL bp_grant_after got %b want 10", req_ready); else n_pass++;
    req_valid = 2'b00;
    @(negedge mclk);
    n_total++; if (busy !== 1'b0) $display("FAIL bp_dropped_req got busy %0b want 0", busy); else n_pass++;
  endtask

  task automatic test_keylen();
    logic [1:0] kl_v [3] = '{2'b10, 2'b11, 2'b01};
    int         req_v[3] = '{0, 1, 0};
    int         lat_v[3] = '{16, 12, 14};
    logic [2:0] oh_v [3] = '{3'b100, 3'b001, 3'b010};
    logic [1:0] g; logic [1:0] exp_g; bit ok; bit held; int cyc;
    for (int i = 0; i < 3; i++) begin
      req_keylen = 4'b0000;
      req_keylen[req_v[i]*2 +: 2] = kl_v[i];
      req_valid = 2'b00;
      req_valid[req_v[i]] = 1'b1;
      exp_g = 2'b01 << req_v[i];
      wait_grant(6, g, ok);
      n_total++; if (!ok || g !== exp_g) $display("FAIL kl_grant%0d got %b want %b", i, g, exp_g); else n_pass++;
      @(negedge mclk);
      req_valid = 2'b00;
      n_total++; if ({keylength256, keylength192, keylength128} !== oh_v[i])
        $display("FAIL kl_onehot%0d got %b want %b", i, {keylength256, keylength192, keylength128}, oh_v[i]); else n_pass++;
      held = 1'b1;
      cyc = 0;
      while (cyc < 40 && rsp_valid !== 1'b1) begin
        @(negedge mclk);
        cyc++;
        if ({keylength256, keylength192, keylength128} !== oh_v[i]) held = 1'b0;
      end
      n_total++; if (cyc != lat_v[i]) $display("FAIL kl_latency%0d got %0d want %0d", i, cyc, lat_v[i]); else n_pass++;
      repeat (2) begin
        @(negedge mclk);
        if ({keylength256, keylength192, keylength128} !== oh_v[i] || rsp_valid !== 1'b1) held = 1'b0;
      end
      n_total++; if (!held) $display("FAIL kl_held%0d got %b want %b", i, {keylength256, keylength192, keylength128}, oh_v[i]); else n_pass++;
      rsp_ready = 1'b1;
      @(negedge mclk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_srst_wait();
    logic [1:0] g; bit ok; bit quiet;
    req_keylen = 4'b0000;
    req_valid = 2'b01;
    wait_grant(6, g, ok);
    n_total++; if (!ok || g !== 2'b01) $display("FAIL srst_grant got %b want 01", g); else n_pass++;
    @(negedge mclk);
    req_valid = 2'b00;
    repeat (3) @(negedge mclk);
    srst = 1'b1;
    @(negedge mclk);
    srst = 1'b0;
    n_total++; if ({busy, rsp_valid, start_enc} !== 3'b000 || plaintext !== 128'd0)
      $display("FAIL srst_idle got %b pt %h want 000 pt 0", {busy, rsp_valid, start_enc}, plaintext); else n_pass++;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge mclk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_total++; if (!quiet) $display("FAIL srst_dv_ignored got valid %0b busy %0b want 0 0", rsp_valid, busy); else n_pass++;
    req_valid = 2'b11;
    wait_grant(4, g, ok);
    n_total++; if (!ok || g !== 2'b01) $display("FAIL srst_rr_ptr got %b want 01", g); else n_pass++;
    req_valid = 2'b00;
    @(negedge mclk);
  endtask

  task automatic test_timeout();
    logic [1:0] g; bit ok; int cyc; bit locked;
    core_mute = 1'b1;
    req_valid = 2'b01;
    wait_grant(6, g, ok);
    n_total++; if (!ok || g !== 2'b01) $display("FAIL to_grant got %b want 01", g); else n_pass++;
    @(negedge mclk);
    req_valid = 2'b00;
    wait_rsp(100, cyc, ok);
    n_total++; if (!ok || cyc != TIMEOUT + 1) $display("FAIL to_latency got %0d want %0d", cyc, TIMEOUT + 1); else n_pass++;
    n_total++; if ({rsp_err, enc_fault, rsp_id} !== 4'b1100) $display("FAIL to_flags got %b want 1100", {rsp_err, enc_fault, rsp_id}); else n_pass++;
    n_total++; if (rsp_ciphertext !== 128'd0) $display("FAIL to_ct got %h want 0", rsp_ciphertext); else n_pass++;
    rsp_ready = 1'b1;
    @(negedge mclk);
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    locked = 1'b1;
    repeat (30) begin
      #1;
      if (req_ready !== 2'b00 || busy !== 1'b0 || enc_fault !== 1'b1) locked = 1'b0;
      @(negedge mclk);
    end
    n_total++; if (!locked) $display("FAIL to_locked got ready %b busy %0b fault %0b want 00 0 1", req_ready, busy, enc_fault); else n_pass++;
    srst = 1'b1;
    @(negedge mclk);
    srst = 1'b0;
    core_mute = 1'b0;
    n_total++; if (enc_fault !== 1'b0) $display("FAIL to_fault_clear got %0b want 0", enc_fault); else n_pass++;
    wait_grant(4, g, ok);
    n_total++; if (!ok || g !== 2'b01) $display("FAIL to_regrant got %b want 01", g); else n_pass++;
    req_valid = 2'b00;
    @(negedge mclk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_keylen();
    test_srst_wait();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
